// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: fill modes, burst
// directions and the burst controller state.
package shift_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ROT = 2'b01;
    localparam logic [1:0] MODE_ARI = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: next register value and the bit that
// falls off the end, for either direction and any fill mode.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             d,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    logic fill;

    // Mode 11 falls into the default arm and behaves as logical.
    always_comb begin
        bit_out = (dir == DIR_RIGHT) ? q[0] : q[WIDTH-1];
        case (mode)
            MODE_ROT: fill = bit_out;
            MODE_ARI: fill = (dir == DIR_RIGHT) ? q[WIDTH-1] : 1'b0;
            default:  fill = d;
        endcase
        if (dir == DIR_RIGHT) begin
            q_next = {fill, q[WIDTH-1:1]};
        end else begin
            q_next = {q[WIDTH-2:0], fill};
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// General-purpose shift register: parallel load, single-step shl/shr and a
// counted burst shift with start/busy/done handshake.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shl,
    input  logic             shr,
    input  logic             d,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] Q,
    output logic             shout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_clamped;
    logic             burst_dir;
    logic             step_dir;
    logic [WIDTH-1:0] q_next;
    logic             bit_out;

    assign n_clamped = (amount > WIDTH_CNT) ? WIDTH_CNT : amount;

    // Outside a burst the single shifter serves shl/shr; shl wins the direction.
    assign step_dir = (state == ST_SHIFT) ? burst_dir : (shl ? DIR_LEFT : DIR_RIGHT);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q      (Q),
        .dir    (step_dir),
        .mode   (mode),
        .d      (d),
        .q_next (q_next),
        .bit_out(bit_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Q         <= '0;
            shout     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
            burst_dir <= DIR_LEFT;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        Q <= pdata;
                    end else if (start) begin
                        if (n_clamped != '0) begin
                            burst_dir <= dir;
                            cnt       <= n_clamped;
                            busy      <= 1'b1;
                            state     <= ST_SHIFT;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else if (shl && shr) begin
                        Q <= Q;
                    end else if (shl || shr) begin
                        Q     <= q_next;
                        shout <= bit_out;
                    end
                end
                ST_SHIFT: begin
                    if (load) begin
                        Q     <= pdata;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        Q     <= q_next;
                        shout <= bit_out;
                        cnt   <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // The done pulse lasts this one cycle; start is not accepted here.
                    state <= ST_IDLE;
                    if (load) begin
                        Q <= pdata;
                    end else if (shl && shr) begin
                        Q <= Q;
                    end else if (shl || shr) begin
                        Q     <= q_next;
                        shout <= bit_out;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH 8, 2 and 32: directed vectors
// on the 8-bit instance, model-checked bursts on the 2- and 32-bit ones.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       d;
    logic [1:0] mode;
    logic       dir;
    logic [2:0] ld, st, sl, sr;

    logic [7:0]  pdata8, q8;
    logic [3:0]  amt8;
    logic [1:0]  pdata2, q2;
    logic [1:0]  amt2;
    logic [31:0] pdata32, q32;
    logic [5:0]  amt32;
    logic        shout8, busy8, done8;
    logic        shout2, busy2, done2;
    logic        shout32, busy32, done32;

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .shl(sl[0]), .shr(sr[0]), .d(d), .load(ld[0]),
        .pdata(pdata8), .mode(mode), .start(st[0]), .dir(dir), .amount(amt8),
        .Q(q8), .shout(shout8), .busy(busy8), .done(done8)
    );

    univ_shift_reg #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .shl(sl[1]), .shr(sr[1]), .d(d), .load(ld[1]),
        .pdata(pdata2), .mode(mode), .start(st[1]), .dir(dir), .amount(amt2),
        .Q(q2), .shout(shout2), .busy(busy2), .done(done2)
    );

    univ_shift_reg #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .shl(sl[2]), .shr(sr[2]), .d(d), .load(ld[2]),
        .pdata(pdata32), .mode(mode), .start(st[2]), .dir(dir), .amount(amt32),
        .Q(q32), .shout(shout32), .busy(busy32), .done(done32)
    );

    typedef struct {
        string       name;
        logic [31:0] q;
        logic        shout;
        logic        busy;
        logic        done;
        int          busyLen;
    } rec_t;

    rec_t snapQ[3][$];
    rec_t burstQ[3][$];
    int   busyCnt[3];
    logic expShout[3];
    int   checks = 0;
    int   errors = 0;

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Snapshot expectation, compared by the monitor at the next falling edge.
    task automatic checkOutput(input int id, input string name, input logic [31:0] q,
                               input logic sh, input logic bz, input logic dn);
        rec_t r;
        r.name = name; r.q = q; r.shout = sh; r.busy = bz; r.done = dn; r.busyLen = 0;
        snapQ[id].push_back(r);
    endtask

    // Burst expectation, compared by the monitor when done pulses.
    task automatic expectBurst(input int id, input string name, input logic [31:0] q,
                               input logic sh, input int len);
        rec_t r;
        r.name = name; r.q = q; r.shout = sh; r.busy = 1'b0; r.done = 1'b1; r.busyLen = len;
        burstQ[id].push_back(r);
    endtask

    task automatic monitorStep(input int id, input logic dn, input logic bz,
                               input logic [31:0] q, input logic sh);
        rec_t r;
        while (snapQ[id].size() > 0) begin
            r = snapQ[id].pop_front();
            checks++;
            if (q !== r.q || sh !== r.shout || bz !== r.busy || dn !== r.done) begin
                errors++;
                $display("[TB] FAIL %s: got Q=%h shout=%b busy=%b done=%b, expected Q=%h shout=%b busy=%b done=%b",
                         r.name, q, sh, bz, dn, r.q, r.shout, r.busy, r.done);
            end
        end
        if (bz === 1'b1) busyCnt[id]++;
        if (dn === 1'b1) begin
            checks++;
            if (burstQ[id].size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done dut%0d: got done=1, expected done=0", id);
            end else begin
                r = burstQ[id].pop_front();
                if (q !== r.q || sh !== r.shout || busyCnt[id] != r.busyLen) begin
                    errors++;
                    $display("[TB] FAIL %s: got Q=%h shout=%b busy_cycles=%0d, expected Q=%h shout=%b busy_cycles=%0d",
                             r.name, q, sh, busyCnt[id], r.q, r.shout, r.busyLen);
                end
            end
        end
        if (bz !== 1'b1 && dn !== 1'b1) busyCnt[id] = 0;
    endtask

    always @(negedge clk) begin
        monitorStep(0, done8, busy8, {24'b0, q8}, shout8);
        monitorStep(1, done2, busy2, {30'b0, q2}, shout2);
        monitorStep(2, done32, busy32, q32, shout32);
    end

    // Independent bit-level reference for an n-step burst of width w.
    task automatic model(input int w, input logic [31:0] qin, input logic [1:0] m,
                         input logic dr, input logic dd, input int n, input logic shin,
                         output logic [31:0] qo, output logic sho);
        logic [63:0] mask;
        logic [31:0] qq;
        logic        o, f;
        mask = (64'd1 << w) - 64'd1;
        qq   = qin;
        sho  = shin;
        for (int i = 0; i < n; i++) begin
            if (dr == DIR_LEFT) begin
                o  = qq[w-1];
                f  = (m == MODE_ROT) ? o : ((m == MODE_ARI) ? 1'b0 : dd);
                qq = 32'(((64'(qq) << 1) | 64'(f)) & mask);
            end else begin
                o  = qq[0];
                f  = (m == MODE_ROT) ? o : ((m == MODE_ARI) ? qq[w-1] : dd);
                qq = (qq >> 1) | (32'(f) << (w - 1));
            end
            sho = o;
        end
        qo = qq;
    endtask

    task automatic load8(input logic [7:0] v);
        pdata8 = v; ld[0] = 1'b1;
        applyStimulus(1);
        ld[0] = 1'b0;
    endtask

    task automatic startBurst8(input logic dr, input logic [3:0] a, input string name,
                               input logic [7:0] eq, input logic es, input int len);
        dir = dr; amt8 = a; st[0] = 1'b1;
        expectBurst(0, name, {24'b0, eq}, es, len);
        applyStimulus(1);
        st[0] = 1'b0;
    endtask

    task automatic sweepBurst(input int id, input int w, input int trial);
        logic [31:0] pd, eq;
        logic [1:0]  m;
        logic        dr, dd, es;
        int          a, n;
        pd = (w == 32) ? $urandom : ($urandom & ((32'd1 << w) - 32'd1));
        m  = 2'($urandom_range(3));
        dr = 1'($urandom_range(1));
        dd = 1'($urandom_range(1));
        a  = $urandom_range((id == 1) ? 3 : 63);
        n  = (a > w) ? w : a;
        if (id == 1) begin pdata2 = pd[1:0]; ld[1] = 1'b1; end
        else begin pdata32 = pd; ld[2] = 1'b1; end
        applyStimulus(1);
        ld[id] = 1'b0;
        mode = m; dir = dr; d = dd;
        if (id == 1) amt2 = 2'(a); else amt32 = 6'(a);
        model(w, pd, m, dr, dd, n, expShout[id], eq, es);
        expectBurst(id, $sformatf("sweep_w%0d_t%0d_m%0d_d%0d_a%0d", w, trial, m, dr, a), eq, es, n);
        expShout[id] = es;
        st[id] = 1'b1;
        applyStimulus(1);
        st[id] = 1'b0;
        applyStimulus(n + 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin busyCnt[i] = 0; expShout[i] = 1'b0; end
        reset = 1'b1; d = 1'b0; mode = MODE_LOG; dir = DIR_LEFT;
        ld = '0; st = '0; sl = '0; sr = '0;
        pdata8 = '0; pdata2 = '0; pdata32 = '0; amt8 = '0; amt2 = '0; amt32 = '0;
        applyStimulus(2);
        reset = 1'b0;
        checkOutput(0, "reset8", 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput(1, "reset2", 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput(2, "reset32", 32'h0, 1'b0, 1'b0, 1'b0);

        // Legacy single-step behaviour.
        sl[0] = 1'b1;
        d = 1'b0; applyStimulus(1);
        d = 1'b1; applyStimulus(1);
        d = 1'b0; applyStimulus(1);
        d = 1'b1; applyStimulus(1);
        checkOutput(0, "legacy_shl", 32'h05, 1'b0, 1'b0, 1'b0);
        sl[0] = 1'b0; sr[0] = 1'b1; d = 1'b0;
        applyStimulus(1);
        checkOutput(0, "legacy_shr1", 32'h02, 1'b1, 1'b0, 1'b0);
        applyStimulus(1);
        checkOutput(0, "legacy_shr2", 32'h01, 1'b0, 1'b0, 1'b0);
        sl[0] = 1'b1;
        applyStimulus(1);
        checkOutput(0, "legacy_hold", 32'h01, 1'b0, 1'b0, 1'b0);
        sl[0] = 1'b0; sr[0] = 1'b0;

        // Arithmetic right burst.
        load8(8'h90);
        mode = MODE_ARI;
        startBurst8(DIR_RIGHT, 4'd3, "ari_r3", 8'hF2, 1'b0, 3);
        applyStimulus(4);

        // Rotate left by WIDTH, by an over-range amount, and by zero.
        load8(8'hA5);
        mode = MODE_ROT;
        startBurst8(DIR_LEFT, 4'd8, "rot_l8", 8'hA5, 1'b1, 8);
        applyStimulus(9);
        startBurst8(DIR_LEFT, 4'd12, "rot_l12", 8'hA5, 1'b1, 8);
        applyStimulus(9);
        startBurst8(DIR_LEFT, 4'd0, "rot_l0", 8'hA5, 1'b1, 0);
        applyStimulus(1);

        // Abort a burst with load; shl must be ignored throughout.
        load8(8'hFF);
        mode = MODE_LOG; d = 1'b0; dir = DIR_RIGHT; amt8 = 4'd6;
        sl[0] = 1'b1; st[0] = 1'b1;
        applyStimulus(1);
        st[0] = 1'b0;
        checkOutput(0, "abort_accept", 32'hFF, 1'b1, 1'b1, 1'b0);
        applyStimulus(1);
        checkOutput(0, "abort_step1", 32'h7F, 1'b1, 1'b1, 1'b0);
        applyStimulus(1);
        pdata8 = 8'h3C; ld[0] = 1'b1;
        applyStimulus(1);
        ld[0] = 1'b0; sl[0] = 1'b0;
        checkOutput(0, "abort_load", 32'h3C, 1'b1, 1'b0, 1'b0);
        applyStimulus(6);
        checkOutput(0, "abort_quiet", 32'h3C, 1'b1, 1'b0, 1'b0);

        // Reset during the third busy cycle, then restart right after release.
        load8(8'h81);
        mode = MODE_LOG; d = 1'b1; dir = DIR_LEFT; amt8 = 4'd5; st[0] = 1'b1;
        applyStimulus(1);
        st[0] = 1'b0;
        applyStimulus(2);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput(0, "reset_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        startBurst8(DIR_LEFT, 4'd2, "after_reset", 8'h03, 1'b0, 2);
        applyStimulus(3);

        // Width sweep against the reference model.
        for (int t = 0; t < 4; t++) begin
            sweepBurst(1, 2, t);
            sweepBurst(2, 32, t);
        end

        applyStimulus(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (burstQ[i].size() != 0 || snapQ[i].size() != 0) begin
                errors++;
                $display("[TB] FAIL pending_dut%0d: got %0d bursts and %0d snapshots outstanding, expected 0",
                         i, burstQ[i].size(), snapQ[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
